// File: rtl/cbc_seq.sv
// cbc_seq: CBC chaining controller between the block stream and an AES round core.
// Owns the IV/chaining register, hands one block at a time to the core via
// core_start/core_done, applies the CBC pre-XOR (encrypt) or post-XOR (decrypt),
// and returns results on a valid/ready stream.
// Ports:
//   clk, reset (async active-low)
//   iv_load/iv_in/encryption/decryption : IV and mode load, IDLE only
//   in_valid/in_ready/in_blk            : input block stream
//   core_start/core_blk/core_done/core_result : AES core handshake
//   out_valid/out_ready/out_blk         : result block stream
//   busy                                : high outside IDLE
module cbc_seq #(
  parameter int unsigned BLK_S   = 128,
  parameter int unsigned IV_BITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iv_load,
  input  logic [IV_BITS-1:0] iv_in,
  input  logic               encryption,
  input  logic               decryption,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_S-1:0]   in_blk,
  output logic               core_start,
  output logic [BLK_S-1:0]   core_blk,
  input  logic               core_done,
  input  logic [BLK_S-1:0]   core_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_S-1:0]   out_blk,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_S-1:0]   iv_q, iv_d;
  logic               mode_enc_q, mode_enc_d;
  logic               iv_ok_q, iv_ok_d;
  logic [BLK_S-1:0]   saved_in_q, saved_in_d;
  logic [BLK_S-1:0]   core_blk_q, core_blk_d;
  logic [BLK_S-1:0]   out_q, out_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      iv_q       <= '0;
      mode_enc_q <= 1'b0;
      iv_ok_q    <= 1'b0;
      saved_in_q <= '0;
      core_blk_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      iv_q       <= iv_d;
      mode_enc_q <= mode_enc_d;
      iv_ok_q    <= iv_ok_d;
      saved_in_q <= saved_in_d;
      core_blk_q <= core_blk_d;
      out_q      <= out_d;
    end
  end

  // Next-state, chaining datapath and handshake outputs
  always_comb begin
    state_d    = state_q;
    iv_d       = iv_q;
    mode_enc_d = mode_enc_q;
    iv_ok_d    = iv_ok_q;
    saved_in_d = saved_in_q;
    core_blk_d = core_blk_q;
    out_d      = out_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        // An IV load owns the cycle, so no block is taken alongside it
        in_ready = iv_ok_q & ~iv_load;
        if (iv_load) begin
          if (encryption ^ decryption) begin
            iv_d       = BLK_S'(iv_in);
            mode_enc_d = encryption;
            iv_ok_d    = 1'b1;
          end
        end else if (in_valid && in_ready) begin
          saved_in_d = in_blk;
          core_blk_d = mode_enc_q ? (in_blk ^ iv_q) : in_blk;
          state_d    = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (mode_enc_q) begin
            out_d = core_result;
            iv_d  = core_result;
          end else begin
            // Decrypt chains on the original ciphertext, not the core input
            out_d = core_result ^ iv_q;
            iv_d  = saved_in_q;
          end
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_blk = core_blk_q;
  assign out_blk  = out_q;

endmodule

// File: doc/cbc_seq.md
# cbc_seq

Sequential CBC chaining controller that sits between the AXI-side block stream and the AES round core. It owns the IV/chaining register and feeds blocks to the core one at a time through a start/done handshake. It applies CBC pre-XOR for encryption and post-XOR for decryption, then returns result blocks on a valid/ready output stream. Keys, rounds and the key schedule are outside this block; it only sequences and chains.

## Interface
- BLK_S, 128, block width in bits
- IV_BITS, 128, IV width; must equal BLK_S
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- iv_load  in  1  load IV and mode; honoured only in IDLE
- iv_in  in  IV_BITS  IV value captured on iv_load
- encryption  in  1  mode select, sampled with iv_load
- decryption  in  1  mode select, sampled with iv_load
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid & in_ready
- in_blk  in  BLK_S  plaintext (enc) or ciphertext (dec)
- core_start  out  1  one-cycle pulse: core_blk is valid, core begins
- core_blk  out  BLK_S  block presented to the AES core, held stable until core_done
- core_done  in  1  core result valid (single-cycle pulse)
- core_result  in  BLK_S  AES core output
- out_valid  out  1  result block valid
- out_ready  in  1  downstream accepts result
- out_blk  out  BLK_S  ciphertext (enc) or plaintext (dec)
- busy  out  1  high in any state other than IDLE

## Operation
- Registers: iv_reg, mode_enc, iv_ok, saved_in (original in_blk), core_blk_reg, out_reg.
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - in_ready = iv_ok.
  - iv_load with exactly one of encryption/decryption high: iv_reg <= iv_in, mode_enc <= encryption, iv_ok <= 1.
  - iv_load with both or neither mode bit high: ignored, no register changes.
  - iv_load has priority over in_valid in the same cycle. in_ready is forced 0 that cycle and the block is not accepted.
  - Accept (in_valid & in_ready): saved_in <= in_blk. core_blk_reg <= in_blk ^ iv_reg for encryption, in_blk for decryption. Next state START.
- START: core_start = 1 for exactly one cycle. Next state WAIT.
- WAIT: hold until core_done.
  - Encryption: out_reg <= core_result, iv_reg <= core_result.
  - Decryption: out_reg <= core_result ^ iv_reg, iv_reg <= saved_in.
  - Next state OUT.
- OUT: out_valid = 1. out_blk = out_reg, held stable. On out_ready, go to IDLE.
- core_done outside WAIT: ignored.
- iv_load outside IDLE: ignored. A new message requires waiting for busy = 0.
- Chaining persists across blocks until the next iv_load.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - iv_ok, in_ready, core_start, out_valid, busy = 0.
  - iv_reg, saved_in, core_blk_reg, out_reg = 0, so core_blk = 0 and out_blk = 0.
  - Reset asserted mid-operation abandons the in-flight block and the IV. A core_done arriving after reset is ignored.
- Cycle numbering: accept at edge T; core_start high during T+1; WAIT starts at T+2.
- With core_done during cycle D, out_valid rises at D+1.
- With out_ready already high, in_ready returns the cycle after out_valid. Minimum per-block overhead is 4 cycles plus core latency.
- core_blk is stable from START until core_done.
- Only one block is in flight; there is no pipelining.
- in_ready is 0 whenever busy = 1.

## Test plan
- Reset/idle:
  - Stimulus: hold reset low, then release; send in_valid without a prior iv_load.
  - Required: all outputs 0; in_ready stays 0 and the block is not accepted.
- Identity-core encryption (bench core returns core_result = core_blk after 3 cycles):
  - Stimulus: IV = 000102030405060708090a0b0c0d0e0f; P1 = ffffffffffffffffffffffffffffffff; P2 = 0.
  - Required: core_blk = fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0; out1 = same value. core_blk for P2 = fffefdfc…f0, so out2 = fffefdfc…f0.
- NIST SP800-38A CBC-AES128 encryption (bench AES model):
  - Stimulus: IV 000102030405060708090a0b0c0d0e0f; P1 6bc1bee22e409f96e93d7e117393172a; P2 ae2d8a571e03ac9c9eb76fac45af8e51.
  - Required: C1 7649abac8119b246cee98e9b12e9197d; C2 5086cb9b507219ee95db113a917678b2.
- Same vectors in decryption mode:
  - Stimulus: feed C1, then C2.
  - Required: P1, then P2. Also check iv_reg = C2 afterwards, by observing the next block's output.
- Backpressure/protocol:
  - Stimulus: hold out_ready low for 10 cycles. Separately, pulse iv_load and core_done while in OUT.
  - Required: out_blk stable, in_ready 0, no change to chaining. The next block still chains from the previous result.
- Corner cases:
  - Stimulus: iv_load with encryption = decryption = 1. Separately, iv_load and in_valid in the same IDLE cycle. Separately, reset asserted during WAIT.
  - Required: the invalid load is ignored. In the simultaneous case, the IV loads and the block is accepted only on the next cycle. After reset in WAIT, out_valid is never raised and iv_ok = 0.
